// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared CPU definitions: next-PC encodings, fetch address map
package pc_ctrl_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JREG   = 3'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE   = 32'h0000_3000;
    localparam logic [31:0] IM_LAST   = 32'h0000_6FFC;

    // Fetch address error: misaligned word or outside the instruction memory window
    function automatic logic adel_check(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    endfunction

endpackage

// File: rtl/pc_ctrl_npc_calc.sv
// rtl/pc_ctrl_npc_calc.sv - combinational next-PC target arithmetic
module npc_calc
    import pc_ctrl_pkg::*;
(
    input  npc_op_e     npc_op_i,
    input  logic        taken_i,
    input  logic [31:0] pc_f_i,
    input  logic [31:0] pc_d_i,
    input  logic [15:0] imm16_i,
    input  logic [25:0] instr_index_i,
    input  logic [31:0] rs_data_i,
    output logic [31:0] npc_o
);

    logic [31:0] seq_pc;
    logic [31:0] br_off;

    assign seq_pc = pc_f_i + 32'd4;
    assign br_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    // Select the target; reserved encodings fall through to sequential fetch
    always_comb begin
        npc_o = seq_pc;
        case (npc_op_i)
            NPC_BRANCH: npc_o = taken_i ? (pc_d_i + 32'd4 + br_off) : seq_pc;
            NPC_JUMP:   npc_o = {pc_d_i[31:28], instr_index_i, 2'b00};
            NPC_JREG:   npc_o = rs_data_i;
            default:    npc_o = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - fetch PC register with redirect priority (optional PC_ADEL_CHECK_EN)
module pc_ctrl
    import pc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic [31:0] cmp_o,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc_f,
    output logic        adel_f
);

    logic [31:0] pc_f_q;
    logic [31:0] pc_f_d;
    logic [31:0] npc;
    logic        load;
    logic        unused_cmp;

    // Only the taken bit of the comparator result matters here
    assign unused_cmp = ^cmp_o[31:1];

    npc_calc u_npc_calc (
        .npc_op_i      (npc_op_e'(npc_op)),
        .taken_i       (cmp_o[0]),
        .pc_f_i        (pc_f_q),
        .pc_d_i        (pc_d),
        .imm16_i       (imm16),
        .instr_index_i (instr_index),
        .rs_data_i     (rs_data),
        .npc_o         (npc)
    );

    // Redirect priority: exception entry, then eret, then stall hold, then decode target
    always_comb begin
        load   = 1'b1;
        pc_f_d = npc;
        if (req) begin
            pc_f_d = EXC_ENTRY;
        end else if (eret) begin
            pc_f_d = epc;
        end else if (stall) begin
            load   = 1'b0;
            pc_f_d = pc_f_q;
        end
    end

    // Fetch PC register; reset discards any redirect in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_q <= PC_RESET;
        end else begin
            pc_f_q <= pc_f_d;
        end
    end

    assign pc_f = pc_f_q;

`ifdef PC_ADEL_CHECK_EN
    logic adel_q;
    logic adel_d;

    assign adel_d = load ? adel_check(pc_f_d) : adel_q;

    // Address-error flag tracks the PC it describes, held together with it on stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adel_q <= 1'b0;
        end else begin
            adel_q <= adel_d;
        end
    end

    assign adel_f = adel_q;
`else
    logic unused_load;
    assign unused_load = load;
    assign adel_f      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb/tb_pc_ctrl.sv - scoreboard bench for pc_ctrl against a behavioural next-PC model
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  npc_op;
    logic [31:0] cmp_o;
    logic [31:0] pc_d;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc_f;
    logic        adel_f;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];
    logic [31:0] model_pc;
    logic        model_adel;

    pc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .npc_op      (npc_op),
        .cmp_o       (cmp_o),
        .pc_d        (pc_d),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_data     (rs_data),
        .req         (req),
        .eret        (eret),
        .epc         (epc),
        .pc_f        (pc_f),
        .adel_f      (adel_f)
    );

    always #5 clk = ~clk;

    function automatic logic exp_adel(input logic [31:0] pc);
`ifdef PC_ADEL_CHECK_EN
        return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6FFC);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req_v);
        end
    endtask

    // Reference: the architectural rules applied to the inputs visible before the edge
    task automatic push_model();
        logic [31:0] n;
        int          off;
        bit          hold;
        hold = 0;
        n    = model_pc + 32'd4;
        if (req)        n = 32'h4180;
        else if (eret)  n = epc;
        else if (stall) hold = 1;
        else if (npc_op == 3'd1 && cmp_o[0]) begin
            off = int'(signed'(imm16));
            n   = pc_d + 32'd4 + 32'(off * 4);
        end
        else if (npc_op == 3'd2) n = (pc_d & 32'hF000_0000) | (32'(instr_index) * 4);
        else if (npc_op == 3'd3) n = rs_data;
        if (!hold) begin
            model_pc   = n;
            model_adel = exp_adel(n);
        end
        exp_q.push_back({model_adel, model_pc});
    endtask

    task automatic step(input logic st, input logic [2:0] op, input logic [31:0] cmp,
                        input logic [31:0] pd, input logic [15:0] im, input logic [25:0] ii,
                        input logic [31:0] rs, input logic rq, input logic er, input logic [31:0] ep);
        @(negedge clk);
        reset = 1'b0;
        stall = st; npc_op = op; cmp_o = cmp; pc_d = pd; imm16 = im;
        instr_index = ii; rs_data = rs; req = rq; eret = er; epc = ep;
        push_model();
    endtask

    task automatic seq();
        step(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_pc"}, pc_f, 32'h3000);
        check({name, "_adel"}, 32'(adel_f), 32'h0);
    endtask

    // Monitor: every registered output after an edge is matched against the oldest expectation
    initial begin
        logic [32:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc_f", pc_f, e[31:0]);
                check("adel_f", 32'(adel_f), 32'(e[32]));
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1; stall = 0; npc_op = 0; cmp_o = 0; pc_d = 0; imm16 = 0;
        instr_index = 0; rs_data = 0; req = 0; eret = 0; epc = 0;
        model_pc = 32'h3000; model_adel = 0;
        repeat (2) @(posedge clk);
        #1 check_reset_state("reset");

        // Sequential fetch after release
        seq(); seq(); seq();

        // Branch taken backwards, then not taken
        step(0, 3'd1, 32'h1, 32'h3010, 16'hFFFC, 0, 0, 0, 0, 0);
        step(0, 3'd1, 32'h0, 32'h3010, 16'hFFFC, 0, 0, 0, 0, 0);
        // Only bit 0 of the comparator counts
        step(0, 3'd1, 32'hFFFF_FFFE, 32'h3010, 16'h0010, 0, 0, 0, 0, 0);

        // Jump and register jump
        step(0, 3'd2, 0, 32'h3020, 0, 26'h0000C40, 0, 0, 0, 0);
        step(0, 3'd3, 0, 0, 0, 0, 32'h3200, 0, 0, 0);

        // Stall holds, exception wins over stall, eret returns
        step(1, 3'd2, 0, 32'h3020, 0, 26'h0000C40, 0, 0, 0, 0);
        step(1, 3'd2, 0, 32'h3020, 0, 26'h0000C40, 0, 0, 0, 0);
        step(1, 3'd2, 0, 32'h3020, 0, 26'h0000C40, 0, 1, 0, 0);
        step(1, 3'd2, 0, 0, 0, 0, 0, 1, 1, 32'h3040);
        step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1, 32'h3040);

        // Address-error flag: misaligned, past the end, last word, and held across a stall
        step(0, 3'd3, 0, 0, 0, 0, 32'h3002, 0, 0, 0);
        step(1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 3'd3, 0, 0, 0, 0, 32'h7000, 0, 0, 0);
        step(0, 3'd3, 0, 0, 0, 0, 32'h6FFC, 0, 0, 0);
        step(0, 3'd3, 0, 0, 0, 0, 32'h2FFC, 0, 0, 0);

        // Reserved encodings behave as sequential; wrap at the top of the address space
        step(0, 3'd5, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 3'd3, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0, 0);
        seq();

        // Asynchronous reset mid-cycle during a stalled branch
        step(0, 3'd3, 0, 0, 0, 0, 32'h5000, 0, 0, 0);
        @(negedge clk);
        stall = 1; npc_op = 3'd1; cmp_o = 1; pc_d = 32'h4000; imm16 = 16'h0040;
        #2 reset = 1'b1;
        #1 check_reset_state("async_reset");
        model_pc = 32'h3000; model_adel = 0;
        @(posedge clk);
        #1 check_reset_state("reset_hold");
        seq();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rs;
            logic [31:0] pd;
            rs = ($urandom_range(0, 3) == 0) ? $urandom :
                 32'h3000 + ($urandom_range(0, 32'h4000) & 32'hFFFF_FFFC) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
            pd = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h3FFC) & 32'hFFFF_FFFC);
            step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), $urandom, pd,
                 16'($urandom), 26'($urandom), rs, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 11) == 0), ($urandom_range(0, 1) == 0) ? rs : $urandom);
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
